l4_fmap_reader: RTL and testbench
=================================

Name: l4_fmap_reader

Overview:
- Reader-side counterpart of the layer-4 pooling writer.
- Once pooling completes, it reads the pooled 5x5 feature maps out of the L4 output BRAM in linear address order. Within a map that order is column-major, with address = row + col*5.
- Words are emitted as a valid/ready stream to the next layer (flatten/FC feeder), tagged with the map index and a last flag.
- It absorbs BRAM read latency and downstream backpressure using a credit-controlled output FIFO.

Parameters:
- DATA_WIDTH, 12, pixel word width.
- ADDR_WIDTH, 12, BRAM read address width.
- MAP_SIZE, 25, words per pooled map (5x5).
- N_MAPS, 16, maps read per run.
- RD_LAT, 2, BRAM read latency in cycles from rd_en to valid rd_dout.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1.

Ports:
- clk, in, 1, clock; all flops rise-edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle run request; ignored while busy.
- base_position, in, ADDR_WIDTH, address of word 0 of map 0; sampled on an accepted start.
- L4_output_read_addr, out, ADDR_WIDTH, BRAM read address.
- L4_output_rd_en, out, 1, BRAM read enable.
- L4_output_dout, in, DATA_WIDTH, BRAM read data; valid RD_LAT cycles after rd_en.
- out_data, out, DATA_WIDTH, stream word.
- out_map, out, 4, map index of out_data.
- out_last, out, 1, high on the final word of the run.
- out_valid, out, 1, stream valid.
- out_ready, in, 1, stream ready; a transfer occurs when valid && ready.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse after the last transfer.

Behaviour:
- Reset values: all outputs 0. FIFO is emptied, read-pipeline valid bits are cleared, state is IDLE.
- Reset mid-run: in-flight BRAM data is discarded and never enters the FIFO.
- States:
  - IDLE: start=1 → READ. On the transition, latch base_position, clear idx (0..N_MAPS*MAP_SIZE-1), pix (0..MAP_SIZE-1) and map (0..N_MAPS-1); busy=1.
  - READ: a read is issued (rd_en=1, addr=base+idx) in a cycle where credits > 0. Each issue advances idx and pix; pix wraps from MAP_SIZE-1 to 0 and increments map at that point. After issuing idx = N_MAPS*MAP_SIZE-1 → DRAIN.
  - DRAIN: no reads issued. Waits until the pipeline and FIFO are empty and the last word has transferred → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Credits:
  - credits = FIFO_DEPTH − fifo_count − reads_in_flight.
  - An issue and a pop in the same cycle are both counted against the credits the cycle began with. Because of this the FIFO can never overflow.
  - At most one issue per cycle.
- Read pipeline:
  - An RD_LAT-deep shift register carries {valid, map, last} alongside each issued read.
  - At the exit edge, L4_output_dout and the carried tag are pushed into the FIFO.
- Latency:
  - With start sampled at edge k, rd_en is high during cycle k+1.
  - First out_valid is high during cycle k+RD_LAT+2.
  - With out_ready=1 throughout, throughput is 1 word/cycle with no bubbles.
- Stream rules:
  - out_data/out_map/out_last come from the FIFO head.
  - They are held stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
  - FIFO push and pop in the same cycle are allowed, including when the FIFO is full with a pop pending.
- Address arithmetic: base + idx, computed to ADDR_WIDTH and wrapping modulo 2^ADDR_WIDTH with no error.
- out_last is high only on word idx = N_MAPS*MAP_SIZE-1.
- done is asserted the cycle after the out_last transfer.
- start is ignored while busy, including during DONE.
- start in the cycle done pulses is not accepted; a new start is accepted from the next IDLE cycle.

Decomposition:
- Shared package lenet_pkg:
  - DATA_WIDTH and L4 constants: L4_MAP_SIZE=25, L4_N_MAPS=16, L4_ROW=5.
  - State enum IDLE/READ/DRAIN/DONE.
- One sub-module, sync_fifo_tag:
  - Parameterised width/depth register FIFO carrying {data, map, last}.
  - Provides count, full and empty outputs.
- The credit logic uses the FIFO's count output.

Test Plan:
- Free-running, out_ready=1, base_position=0: start at edge 10 → first out_valid in cycle 14, 400 consecutive beats. Beat n has out_data = BRAM model[n] and out_map = n/25. out_last only on beat 399; done pulse in the cycle after; busy low after.
- Backpressure: out_ready toggles 1 cycle on / 3 off. Required: FIFO count never exceeds 4, no word lost or duplicated, order preserved, data stable while stalled.
- out_ready=0 for 50 cycles after start: exactly 4 reads issued, then rd_en stays 0. On ready release, stream resumes at word 4 with no gaps.
- Address wrap, base_position=12'hFF0: addresses FF0..FFF then 000..17F (400 reads). Data matches BRAM model at the wrapped addresses.
- Reset mid-run: rst_n low at beat 137 → all outputs 0 immediately. A new start after release streams from word 0 with no stale words from the aborted run.
- start pulsed during READ and DRAIN: no restart, idx unaffected, exactly one done.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types used by the layer-4 readers and writers.
//   DATA_WIDTH   : pixel word width
//   L4_ROW       : side length of a pooled layer-4 map
//   L4_MAP_SIZE  : words per pooled layer-4 map
//   L4_N_MAPS    : number of pooled layer-4 maps
//   L4_MAP_IDX_W : width of a layer-4 map index
//   rd_state_e   : reader control states
package lenet_pkg;

    localparam int DATA_WIDTH   = 12;
    localparam int L4_ROW       = 5;
    localparam int L4_MAP_SIZE  = L4_ROW * L4_ROW;
    localparam int L4_N_MAPS    = 16;
    localparam int L4_MAP_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/sync_fifo_tag.sv
// Register-based synchronous FIFO carrying packed {data, map, last} tags.
//   clk, rst_n : clock and asynchronous active-low reset (storage cleared)
//   push/wdata : write request and word; accepted when not full or a pop is
//                taken in the same cycle
//   pop/rdata  : read request and head word; pop is ignored when empty
//   count      : number of stored entries
//   full/empty : occupancy flags
module sync_fifo_tag #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH-1)) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH-1)) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/l4_fmap_reader.sv
// Layer-4 feature-map reader: streams the pooled maps out of the L4 output
// BRAM in linear address order (column-major within a map) as a valid/ready
// stream tagged with the map index and a last flag.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, base_position : run request and address of word 0 of map 0
//   L4_output_read_addr  : BRAM read address (base + idx, wraps)
//   L4_output_rd_en      : BRAM read enable
//   L4_output_dout       : BRAM data, valid RD_LAT cycles after rd_en
//   out_data/map/last    : stream word and its tags from the FIFO head
//   out_valid, out_ready : stream handshake
//   busy, done           : run in progress / one-cycle completion pulse
module l4_fmap_reader
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int MAP_SIZE   = L4_MAP_SIZE,
    parameter int N_MAPS     = L4_N_MAPS,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_position,
    output logic [ADDR_WIDTH-1:0] L4_output_read_addr,
    output logic                  L4_output_rd_en,
    input  logic [DATA_WIDTH-1:0] L4_output_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_map,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL = N_MAPS * MAP_SIZE;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int PIX_W = $clog2(MAP_SIZE);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam int TAG_W = DATA_WIDTH + 4 + 1;

    rd_state_e             state_r;
    rd_state_e             state_nxt_s;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [IDX_W-1:0]      idx_r;
    logic [PIX_W-1:0]      pix_r;
    logic [3:0]            map_r;

    logic                  pipe_vld_r  [RD_LAT];
    logic [3:0]            pipe_map_r  [RD_LAT];
    logic                  pipe_last_r [RD_LAT];

    logic [OCC_W-1:0]      in_flight_s;
    logic [OCC_W-1:0]      occupancy_s;
    logic                  issue_s;
    logic                  issue_last_s;
    logic                  push_s;
    logic [TAG_W-1:0]      push_tag_s;
    logic                  pop_s;
    logic [TAG_W-1:0]      head_tag_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    // Reads still travelling through the BRAM latency pipeline.
    always_comb begin
        in_flight_s = OCC_W'(0);
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight_s = in_flight_s + OCC_W'(pipe_vld_r[i]);
        end
    end

    // Credits are judged on the state the cycle began with: a pop in the same
    // cycle does not free a slot for this cycle's issue, so the FIFO can never
    // be over-committed.
    assign occupancy_s  = OCC_W'(fifo_count_s) + in_flight_s;
    assign issue_s      = (state_r == READ) && !fifo_full_s && (occupancy_s < OCC_W'(FIFO_DEPTH));
    assign issue_last_s = (idx_r == IDX_W'(TOTAL - 1));

    assign push_s     = pipe_vld_r[RD_LAT-1];
    assign push_tag_s = {L4_output_dout, pipe_map_r[RD_LAT-1], pipe_last_r[RD_LAT-1]};
    assign pop_s      = !fifo_empty_s && out_ready;

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DRAIN ends on the transfer of the last word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (issue_s && issue_last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = READ;
                end
            end
            DRAIN: begin
                if (pop_s && head_tag_s[0]) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Run counters: linear word index, pixel within map, map index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= ADDR_WIDTH'(0);
            idx_r  <= IDX_W'(0);
            pix_r  <= PIX_W'(0);
            map_r  <= 4'd0;
        end else if ((state_r == IDLE) && start) begin
            base_r <= base_position;
            idx_r  <= IDX_W'(0);
            pix_r  <= PIX_W'(0);
            map_r  <= 4'd0;
        end else if (issue_s) begin
            idx_r <= idx_r + IDX_W'(1);
            if (pix_r == PIX_W'(MAP_SIZE - 1)) begin
                pix_r <= PIX_W'(0);
                map_r <= map_r + 4'd1;
            end else begin
                pix_r <= pix_r + PIX_W'(1);
            end
        end
    end

    // Tag shift register aligned with the BRAM read latency; reset drops any
    // read still in flight so its data never reaches the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= 1'b0;
                pipe_map_r[i]  <= 4'd0;
                pipe_last_r[i] <= 1'b0;
            end
        end else begin
            pipe_vld_r[0]  <= issue_s;
            pipe_map_r[0]  <= map_r;
            pipe_last_r[0] <= issue_last_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_map_r[i]  <= pipe_map_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
            end
        end
    end

    sync_fifo_tag #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (push_tag_s),
        .pop   (pop_s),
        .rdata (head_tag_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // All outputs decode from flops only (state, counters, FIFO registers).
    assign L4_output_rd_en     = issue_s;
    assign L4_output_read_addr = base_r + ADDR_WIDTH'(idx_r);
    assign out_data            = head_tag_s[TAG_W-1 -: DATA_WIDTH];
    assign out_map             = head_tag_s[4:1];
    assign out_last            = head_tag_s[0];
    assign out_valid           = !fifo_empty_s;
    assign busy                = (state_r == READ) || (state_r == DRAIN);
    assign done                = (state_r == DONE);

endmodule

// File: tb/tb_l4_fmap_reader.sv
// Self-checking bench for l4_fmap_reader: BRAM model with 2-cycle latency,
// a stream scoreboard derived from the addressing rules, and directed runs.
module tb_l4_fmap_reader;

    localparam int DW     = 12;
    localparam int AW     = 12;
    localparam int TOTAL  = 400;
    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_position;
    logic [AW-1:0] L4_output_read_addr;
    logic          L4_output_rd_en;
    logic [DW-1:0] L4_output_dout;
    logic [DW-1:0] out_data;
    logic [3:0]    out_map;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    l4_fmap_reader dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .base_position       (base_position),
        .L4_output_read_addr (L4_output_read_addr),
        .L4_output_rd_en     (L4_output_rd_en),
        .L4_output_dout      (L4_output_dout),
        .out_data            (out_data),
        .out_map             (out_map),
        .out_last            (out_last),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .busy                (busy),
        .done                (done)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] bram [4096];
    logic [DW-1:0] bram_s1;

    function automatic logic [DW-1:0] pix_fn(input int a);
        logic [31:0] v;
        v = a * 37 + 11;
        return v[DW-1:0];
    endfunction

    // BRAM model: address sampled with rd_en, data two edges later.
    always @(posedge clk) begin
        if (L4_output_rd_en) bram_s1 <= bram[L4_output_read_addr];
        L4_output_dout <= bram_s1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard state ----------------
    bit            run_active = 1'b0;
    bit            accept_pending = 1'b0;
    bit            accept_now;
    bit            done_exp = 1'b0;
    bit            done_nxt = 1'b0;
    bit            stall_prev = 1'b0;
    int            rel = 0;
    int            exp_issue = 0;
    int            exp_beat = 0;
    int            runs_done = 0;
    int            last_run_beats = 0;
    int            last_beat_rel = 0;
    logic [AW-1:0] cur_base = '0;
    logic [AW-1:0] base_pend = '0;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] prev_data;
    logic [3:0]    prev_map;
    logic          prev_last;
    logic [DW-1:0] got_data [TOTAL];
    logic [3:0]    got_map  [TOTAL];
    logic [AW-1:0] got_addr [TOTAL];

    // Compare process: checks every DUT output on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_active     = 1'b0;
            accept_pending = 1'b0;
            done_exp       = 1'b0;
            done_nxt       = 1'b0;
            stall_prev     = 1'b0;
        end else begin
            done_exp = done_nxt;
            done_nxt = 1'b0;
            if (accept_pending) begin
                run_active     = 1'b1;
                accept_pending = 1'b0;
                rel            = 0;
                exp_issue      = 0;
                exp_beat       = 0;
                cur_base       = base_pend;
            end else begin
                rel++;
            end
            accept_now = start && !run_active;

            chk("done", done, done_exp);
            chk("busy", busy, run_active && !done_exp);
            if (run_active && rel == 0)        chk("first rd_en latency", L4_output_rd_en, 1);
            if (run_active && rel == RD_LAT)   chk("valid not early", out_valid, 0);
            if (run_active && rel == RD_LAT+1) chk("first valid latency", out_valid, 1);

            if (L4_output_rd_en) begin
                if (!run_active || exp_issue >= TOTAL) begin
                    chk("rd_en outside run", L4_output_rd_en, 0);
                end else begin
                    exp_addr = cur_base + AW'(exp_issue);
                    got_addr[exp_issue] = L4_output_read_addr;
                    chk("read address", L4_output_read_addr, exp_addr);
                    exp_issue++;
                    chk("credit bound", (exp_issue - exp_beat) <= DEPTH, 1);
                end
            end

            if (stall_prev) begin
                chk("valid held in stall", out_valid, 1);
                chk("data held in stall", out_data, prev_data);
                chk("map held in stall", out_map, prev_map);
                chk("last held in stall", out_last, prev_last);
            end

            if (out_valid && out_ready) begin
                if (!run_active || exp_beat >= TOTAL) begin
                    chk("transfer outside run", out_valid, 0);
                end else begin
                    exp_addr = cur_base + AW'(exp_beat);
                    chk("out_data", out_data, bram[exp_addr]);
                    chk("out_map", out_map, exp_beat / 25);
                    chk("out_last", out_last, exp_beat == TOTAL-1);
                    got_data[exp_beat] = out_data;
                    got_map[exp_beat]  = out_map;
                    if (exp_beat == TOTAL-1) begin
                        done_nxt      = 1'b1;
                        last_beat_rel = rel;
                    end
                    exp_beat++;
                end
            end

            if (done_exp) begin
                run_active     = 1'b0;
                runs_done++;
                last_run_beats = exp_beat;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_map   = out_map;
            prev_last  = out_last;
            if (accept_now) begin
                accept_pending = 1'b1;
                base_pend      = base_position;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_zero_outputs(input string tag);
        chk({tag, " addr"},  L4_output_read_addr, 0);
        chk({tag, " rd_en"}, L4_output_rd_en, 0);
        chk({tag, " data"},  out_data, 0);
        chk({tag, " map"},   out_map, 0);
        chk({tag, " last"},  out_last, 0);
        chk({tag, " valid"}, out_valid, 0);
        chk({tag, " busy"},  busy, 0);
        chk({tag, " done"},  done, 0);
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        @(posedge clk); #1;
        base_position = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_runs(input int target, input int limit);
        int n = 0;
        while (runs_done < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("run completes", runs_done, target);
    endtask

    initial begin
        int k;
        bit drain_pulsed;
        for (int a = 0; a < 4096; a++) bram[a] = pix_fn(a);
        rst_n = 1'b0; start = 1'b0; base_position = '0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Run 1: free-running, start sampled at edge 10.
        repeat (6) @(posedge clk);
        #1 start = 1'b1; base_position = 12'h000;
        @(posedge clk); #1 start = 1'b0;
        wait_runs(1, 1000);
        chk("run1 beats", last_run_beats, TOTAL);
        chk("run1 no bubbles", last_beat_rel, RD_LAT + 1 + TOTAL - 1);
        chk("run1 word0 data", got_data[0], 12'd11);
        chk("run1 word25 data", got_data[25], 12'd936);
        chk("run1 word25 map", got_map[25], 4'd1);
        chk("run1 word399 data", got_data[399], 12'd2486);
        chk("run1 word399 map", got_map[399], 4'd15);
        @(posedge clk); #1 chk("run1 idle busy", busy, 0);

        // Run 2: 1-on/3-off backpressure, start pulses in READ, DRAIN and DONE.
        pulse_start(12'h100);
        k = 0; drain_pulsed = 1'b0;
        while (runs_done < 2 && k < 5000) begin
            @(posedge clk); #1;
            out_ready = (k % 4 == 0);
            start = 1'b0;
            if (k == 30) begin start = 1'b1; base_position = 12'h777; end
            if (!drain_pulsed && run_active && exp_issue == TOTAL) begin
                start = 1'b1; base_position = 12'h555; drain_pulsed = 1'b1;
            end
            if (done_nxt) start = 1'b1;
            k++;
        end
        start = 1'b0; out_ready = 1'b1;
        chk("bp run completes", runs_done, 2);
        chk("bp beats", last_run_beats, TOTAL);
        repeat (20) @(posedge clk);
        #1 chk("bp no restart", runs_done, 2);
        chk("bp idle busy", busy, 0);

        // Run 3: ready held low for 50 cycles after start.
        out_ready = 1'b0;
        pulse_start(12'h020);
        repeat (50) @(posedge clk);
        #1 chk("stalled issue count", exp_issue, DEPTH);
        chk("stalled rd_en", L4_output_rd_en, 0);
        chk("stalled valid", out_valid, 1);
        out_ready = 1'b1;
        wait_runs(3, 1000);
        chk("stall run beats", last_run_beats, TOTAL);

        // Run 4: address wrap from 12'hFF0.
        pulse_start(12'hFF0);
        wait_runs(4, 1000);
        chk("wrap addr0", got_addr[0], 12'hFF0);
        chk("wrap addr15", got_addr[15], 12'hFFF);
        chk("wrap addr16", got_addr[16], 12'h000);
        chk("wrap addr399", got_addr[399], 12'h17F);
        chk("wrap word0 data", got_data[0], 12'd3515);
        chk("wrap word16 data", got_data[16], 12'd11);

        // Run 5: reset around beat 137, then a clean run.
        pulse_start(12'h000);
        k = 0;
        while (exp_beat < 137 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        chk("reached beat 137", exp_beat >= 137, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_zero_outputs("mid-run reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start(12'h000);
        wait_runs(5, 1000);
        chk("post-reset beats", last_run_beats, TOTAL);
        chk("post-reset word0", got_data[0], 12'd11);
        chk("post-reset word137", got_data[137], 12'd984);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
